// File: rtl/lcd_hd44780_responder_pkg.sv
// Shared constants, FSM encoding and address helpers for the HD44780 responder.
package lcd_hd44780_responder_pkg;

  localparam logic [7:0] OP_CLR   = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_SHIFT = 8'h10;
  localparam logic [7:0] OP_FUNC  = 8'h20;
  localparam logic [7:0] OP_CGRAM = 8'h40;
  localparam logic [7:0] OP_DDRAM = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE_LEN   = 7'h28;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_LAST = 7'h67;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam int         DDRAM_DEPTH = 80;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} state_e;

  function automatic logic addr_valid(input logic [6:0] a);
    return a[5:0] < LINE_LEN[5:0];
  endfunction

  // Line 2 (0x40..0x67) is packed directly after line 1 in the 80-byte array.
  function automatic logic [6:0] ddram_idx(input logic [6:0] a);
    return a[6] ? ({1'b0, a[5:0]} + LINE_LEN) : {1'b0, a[5:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == LINE1_LAST) return LINE2_BASE;
      if (a == LINE2_LAST) return LINE1_BASE;
      return a + 7'd1;
    end
    if (a == LINE2_BASE) return LINE1_LAST;
    if (a == LINE1_BASE) return LINE2_LAST;
    return a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// LCD parallel bus as seen between the driver (master) and this responder (slave).
interface lcd_hd44780_responder_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_data_in,
                  input  lcd_data_out, lcd_data_oe);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_data_in,
                  output lcd_data_out, lcd_data_oe);
endinterface

// File: rtl/lcd_hd44780_responder_ddram.sv
// 80x8 display RAM: one write port, registered bus read and registered monitor read.
module lcd_hd44780_responder_ddram
  import lcd_hd44780_responder_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic [6:0] bus_idx,
  output logic [7:0] bus_data,
  input  logic [6:0] mon_addr,
  output logic [7:0] mon_data
);

  logic [7:0] mem [DDRAM_DEPTH];
  logic [7:0] bus_q;
  logic [7:0] mon_q;
  logic       mon_valid_q;

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
    bus_q       <= mem[bus_idx];
    mon_q       <= mem[ddram_idx(mon_addr)];
    mon_valid_q <= addr_valid(mon_addr);
  end

  assign bus_data = bus_q;
  assign mon_data = mon_valid_q ? mon_q : CHAR_SPACE;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible bus responder: synchronises the LCD bus, decodes instructions,
// owns the DDRAM, address counter and mode flags.
//   state    | meaning
//   ST_IDLE  | ready, next strobe is executed
//   ST_EXEC  | busy for CMD_CYCLES after an instruction or data write
//   ST_CLEAR | busy for CLEAR_CYCLES; fills DDRAM with spaces unless entered by Home
module lcd_hd44780_responder
  import lcd_hd44780_responder_pkg::*;
#(
  parameter int CMD_CYCLES   = 4,
  parameter int CLEAR_CYCLES = 96
) (
  input  logic       clk,
  input  logic       rst,
  lcd_hd44780_responder_if.slave bus,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       addr_inc,
  output logic       shift_en,
  output logic       dl_8bit,
  output logic       two_line,
  output logic       cmd_err
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CYCLES - 1);

  logic [2:0] e_q;
  logic [1:0] rs_q, rw_q;
  logic [7:0] din1_q, din2_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, clr_cnt;
  logic [6:0]       ac_q, ac_d;
  logic disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d, inc_q, inc_d;
  logic shift_q, shift_d, dl_q, dl_d, two_q, two_d, home_q, home_d;
  logic cmd_err_q, cmd_err_d;

  logic       strobe, rs_s, rw_s, oe;
  logic [7:0] din_s, ram_bus;
  logic       ram_we;
  logic [6:0] ram_wr_idx;
  logic [7:0] ram_wr_data;

  // e_q[1] is the synced enable; e_q[2] only exists to find its falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q    <= '0;
      rs_q   <= '0;
      rw_q   <= '0;
      din1_q <= '0;
      din2_q <= '0;
    end else begin
      e_q    <= {e_q[1:0], bus.lcd_e};
      rs_q   <= {rs_q[0], bus.lcd_rs};
      rw_q   <= {rw_q[0], bus.lcd_rw};
      din1_q <= bus.lcd_data_in;
      din2_q <= din1_q;
    end
  end

  assign strobe  = e_q[2] & ~e_q[1];
  assign rs_s    = rs_q[1];
  assign rw_s    = rw_q[1];
  assign din_s   = din2_q;
  assign clr_cnt = CLEAR_LAST - cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= CLEAR_LAST;
      ac_q      <= '0;
      disp_q    <= 1'b0;
      cursor_q  <= 1'b0;
      blink_q   <= 1'b0;
      inc_q     <= 1'b1;
      shift_q   <= 1'b0;
      dl_q      <= 1'b1;
      two_q     <= 1'b0;
      home_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ac_q      <= ac_d;
      disp_q    <= disp_d;
      cursor_q  <= cursor_d;
      blink_q   <= blink_d;
      inc_q     <= inc_d;
      shift_q   <= shift_d;
      dl_q      <= dl_d;
      two_q     <= two_d;
      home_q    <= home_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ac_d        = ac_q;
    disp_d      = disp_q;
    cursor_d    = cursor_q;
    blink_d     = blink_q;
    inc_d       = inc_q;
    shift_d     = shift_q;
    dl_d        = dl_q;
    two_d       = two_q;
    home_d      = home_q;
    cmd_err_d   = 1'b0;
    ram_we      = 1'b0;
    ram_wr_idx  = ddram_idx(ac_q);
    ram_wr_data = din_s;
    unique case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          if (rs_s && !rw_s) begin
            ram_we  = 1'b1;
            ac_d    = ac_step(ac_q, inc_q);
            state_d = ST_EXEC;
            cnt_d   = CMD_LAST;
          end else if (rs_s) begin
            ac_d = ac_step(ac_q, inc_q);
          end else if (!rw_s) begin
            state_d = ST_EXEC;
            cnt_d   = CMD_LAST;
            if (|(din_s & OP_DDRAM)) begin
              if (addr_valid(din_s[6:0])) ac_d = din_s[6:0];
              else begin
                cmd_err_d = 1'b1;
                state_d   = ST_IDLE;
              end
            end else if (|(din_s & OP_CGRAM)) begin
              // CGRAM is not modelled; the instruction only costs busy time.
              ac_d = ac_q;
            end else if (|(din_s & OP_FUNC)) begin
              dl_d  = din_s[4];
              two_d = din_s[3];
            end else if (|(din_s & OP_SHIFT)) begin
              if (!din_s[3]) ac_d = ac_step(ac_q, din_s[2]);
            end else if (|(din_s & OP_DISP)) begin
              disp_d   = din_s[2];
              cursor_d = din_s[1];
              blink_d  = din_s[0];
            end else if (|(din_s & OP_ENTRY)) begin
              inc_d   = din_s[1];
              shift_d = din_s[0];
            end else if (|(din_s & OP_HOME)) begin
              ac_d    = '0;
              home_d  = 1'b1;
              state_d = ST_CLEAR;
              cnt_d   = CLEAR_LAST;
            end else if (|(din_s & OP_CLR)) begin
              ac_d    = '0;
              inc_d   = 1'b1;
              home_d  = 1'b0;
              state_d = ST_CLEAR;
              cnt_d   = CLEAR_LAST;
            end
          end
        end
      end
      default: begin
        if (strobe && (rs_s || !rw_s)) cmd_err_d = 1'b1;
        if (state_q == ST_CLEAR && !home_q && clr_cnt < CNT_W'(DDRAM_DEPTH)) begin
          ram_we      = 1'b1;
          ram_wr_idx  = clr_cnt[6:0];
          ram_wr_data = CHAR_SPACE;
        end
        if (cnt_q == '0) state_d = ST_IDLE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
    endcase
  end

  lcd_hd44780_responder_ddram u_ddram (
    .clk      (clk),
    .we       (ram_we),
    .wr_idx   (ram_wr_idx),
    .wr_data  (ram_wr_data),
    .bus_idx  (ddram_idx(ac_q)),
    .bus_data (ram_bus),
    .mon_addr (rd_addr),
    .mon_data (rd_char)
  );

  assign oe               = e_q[1] & rw_q[1];
  assign bus.lcd_data_oe  = oe;
  assign bus.lcd_data_out = oe ? (rs_s ? ram_bus : {busy, ac_q}) : 8'h00;

  assign busy      = (state_q != ST_IDLE);
  assign ac        = ac_q;
  assign disp_on   = disp_q;
  assign cursor_on = cursor_q;
  assign blink_on  = blink_q;
  assign addr_inc  = inc_q;
  assign shift_en  = shift_q;
  assign dl_8bit   = dl_q;
  assign two_line  = two_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench: bus-operation vector table plus hand sequences for busy/reset corners.
module tb_lcd_hd44780_responder;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] d;
    logic       wt;
    logic       err;
    logic [6:0] ac;
    logic [6:0] fl;
    logic       chk_rd;
    logic [7:0] rd;
  } vec_t;

  localparam logic [6:0] FL_RST = 7'b0001010;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic       busy;
  logic [6:0] ac;
  logic       disp_on, cursor_on, blink_on, addr_inc, shift_en, dl_8bit, two_line;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  logic [7:0] mdl [128];
  vec_t tbl [$];

  lcd_hd44780_responder_if bus ();

  lcd_hd44780_responder dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .rd_addr(rd_addr), .rd_char(rd_char), .busy(busy), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .addr_inc(addr_inc), .shift_en(shift_en), .dl_8bit(dl_8bit),
    .two_line(two_line), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_err) err_seen++;

  function automatic logic [6:0] flags();
    return {disp_on, cursor_on, blink_on, addr_inc, shift_en, dl_8bit, two_line};
  endfunction

  function automatic vec_t mk(input logic rs, input logic rw, input logic [7:0] d,
                              input logic wt, input logic err, input logic [6:0] a,
                              input logic [6:0] fl, input logic chk_rd, input logic [7:0] rd);
    vec_t v;
    v = '{rs: rs, rw: rw, d: d, wt: wt, err: err, ac: a, fl: fl, chk_rd: chk_rd, rd: rd};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy still 1 after %0d cycles expected 0", n);
    end
  endtask

  task automatic do_op(input logic rs_v, input logic rw_v, input logic [7:0] d,
                       output logic [7:0] rd);
    @(negedge clk);
    bus.lcd_rs = rs_v;
    bus.lcd_rw = rw_v;
    bus.lcd_data_in = d;
    bus.lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    rd = bus.lcd_data_out;
    bus.lcd_e = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int e0;
    logic [7:0] rd;
    e0 = err_seen;
    do_op(v.rs, v.rw, v.d, rd);
    if (v.wt) wait_idle();
    chk($sformatf("v%0d_err", idx), 32'(err_seen - e0), 32'(v.err));
    chk($sformatf("v%0d_ac", idx), 32'(ac), 32'(v.ac));
    chk($sformatf("v%0d_flags", idx), 32'(flags()), 32'(v.fl));
    if (v.chk_rd) chk($sformatf("v%0d_rd", idx), 32'(rd), 32'(v.rd));
  endtask

  // Monitor port scoreboard: expected byte queued when the address is driven,
  // compared one cycle later when rd_char is valid.
  task automatic dump_chk(input string nm);
    logic [7:0] q [$];
    for (int a = 0; a <= 128; a++) begin
      @(negedge clk);
      if (q.size() > 0) chk($sformatf("%s[%02h]", nm, a - 1), 32'(rd_char), 32'(q.pop_front()));
      if (a < 128) begin
        rd_addr = 7'(a);
        q.push_back(mdl[a]);
      end
    end
  endtask

  task automatic reset_release_chk(input string nm);
    int n = 0;
    @(negedge clk);
    rst = 1'b1;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_len"}, 32'(n), 32'd96);
    chk({nm, "_ac"}, 32'(ac), 32'h0);
    chk({nm, "_flags"}, 32'(flags()), 32'(FL_RST));
  endtask

  initial begin
    int na;
    vec_t v;
    logic [7:0] rd;
    int n;
    bus.lcd_e = 1'b0;
    bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b0;
    bus.lcd_data_in = 8'h00;
    for (int i = 0; i < 128; i++) mdl[i] = 8'h20;

    #23;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ac", 32'(ac), 32'h0);
    chk("rst_flags", 32'(flags()), 32'(FL_RST));
    chk("rst_out", 32'({bus.lcd_data_oe, bus.lcd_data_out}), 32'h0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    reset_release_chk("boot");
    dump_chk("boot_ram");

    //            rs rw d      wt err ac     flags        chk rd
    tbl.push_back(mk(0, 0, 8'h38, 1, 0, 7'h00, 7'b0001011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h0C, 1, 0, 7'h00, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h06, 1, 0, 7'h00, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h80, 1, 0, 7'h00, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h54, 1, 0, 7'h01, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h69, 1, 0, 7'h02, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h80, 1, 0, 7'h00, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(1, 1, 8'h00, 1, 0, 7'h01, 7'b1001011, 1, 8'h54));
    tbl.push_back(mk(0, 1, 8'h00, 1, 0, 7'h01, 7'b1001011, 1, 8'h01));
    tbl.push_back(mk(0, 0, 8'hA7, 1, 0, 7'h27, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h58, 1, 0, 7'h40, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'hE7, 1, 0, 7'h67, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h59, 1, 0, 7'h00, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h14, 1, 0, 7'h01, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 7'h00, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 7'h67, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h1C, 1, 0, 7'h67, 7'b1001011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h0F, 1, 0, 7'h67, 7'b1111011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h05, 1, 0, 7'h67, 7'b1110111, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h06, 1, 0, 7'h67, 7'b1111011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h40, 1, 0, 7'h67, 7'b1111011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h20, 1, 0, 7'h67, 7'b1111000, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h38, 1, 0, 7'h67, 7'b1111011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h02, 1, 0, 7'h00, 7'b1111011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'hE8, 1, 1, 7'h00, 7'b1111011, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'hA8, 1, 1, 7'h00, 7'b1111011, 0, 8'h00));
    na = tbl.size();
    // Clear, then a data write while the clear is still busy.
    tbl.push_back(mk(0, 0, 8'h01, 0, 0, 7'h00, 7'b1111011, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h41, 1, 1, 7'h00, 7'b1111011, 0, 8'h00));

    for (int i = 0; i < na; i++) run_vec(tbl[i], i);
    mdl[8'h00] = 8'h54;
    mdl[8'h01] = 8'h69;
    mdl[8'h27] = 8'h58;
    mdl[8'h67] = 8'h59;
    dump_chk("text_ram");

    for (int i = na; i < tbl.size(); i++) run_vec(tbl[i], i);
    for (int i = 0; i < 128; i++) mdl[i] = 8'h20;
    dump_chk("cleared_ram");

    // Busy read while the 0xC5 set-address instruction is still executing.
    @(negedge clk);
    bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b0;
    bus.lcd_data_in = 8'hC5;
    bus.lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    bus.lcd_e = 1'b0;
    @(negedge clk);
    bus.lcd_rw = 1'b1;
    bus.lcd_e = 1'b1;
    n = 0;
    while (!bus.lcd_data_oe && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("exec_busy_rd", 32'({bus.lcd_data_oe, bus.lcd_data_out}), 32'h1C5);
    chk("exec_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    bus.lcd_e = 1'b0;
    repeat (6) @(negedge clk);
    wait_idle();
    run_vec(mk(0, 1, 8'h00, 1, 0, 7'h45, 7'b1111011, 1, 8'h45), 100);
    run_vec(mk(0, 0, 8'hB0, 1, 1, 7'h45, 7'b1111011, 0, 8'h00), 101);

    // Decrement wrap from line 2 start, then reset in the middle of a clear.
    run_vec(mk(0, 0, 8'h04, 1, 0, 7'h45, 7'b1110011, 0, 8'h00), 102);
    run_vec(mk(0, 0, 8'hC0, 1, 0, 7'h40, 7'b1110011, 0, 8'h00), 103);
    run_vec(mk(1, 0, 8'h33, 1, 0, 7'h27, 7'b1110011, 0, 8'h00), 104);
    run_vec(mk(0, 0, 8'h01, 0, 0, 7'h00, 7'b1111011, 0, 8'h00), 105);
    repeat (37) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_ac", 32'(ac), 32'h0);
    chk("mid_rst_flags", 32'(flags()), 32'(FL_RST));
    chk("mid_rst_cmd_err", 32'(cmd_err), 32'd0);
    repeat (3) @(negedge clk);
    reset_release_chk("rerun");
    dump_chk("rerun_ram");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
